// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-write path.
package sccb_pkg;

    localparam logic [6:0] SCCB_DEV_ADDR   = 7'h3C;
    localparam int         SCCB_REGWRITE_W = 24;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_BYTE_HI,
        ARB_BYTE_LO,
        ARB_BYTE_DATA,
        ARB_DRAIN,
        ARB_GAP
    } sccb_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        // Walk from the farthest slot to the nearest so the slot right after ptr wins.
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/sccb_write_arbiter.sv
// Round-robin sharing of one SCCB master between register-write requesters;
// each grant becomes start/write-multiple/stop plus three streamed bytes.
module sccb_write_arbiter
    import sccb_pkg::*;
#(
    parameter  int         NUM_REQ    = 2,
    parameter  logic [6:0] DEV_ADDR   = SCCB_DEV_ADDR,
    parameter  int         GAP_CYCLES = 16,
    localparam int         IW         = $clog2(NUM_REQ)
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [SCCB_REGWRITE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic                               done_valid,
    output logic [IW-1:0]                      done_id,
    output logic                               done_nack,
    output logic                               active,
    output logic [6:0]                         cmd_address,
    output logic                               cmd_start,
    output logic                               cmd_read,
    output logic                               cmd_write,
    output logic                               cmd_write_multiple,
    output logic                               cmd_stop,
    output logic                               cmd_valid,
    input  logic                               cmd_ready,
    output logic [7:0]                         data_tdata,
    output logic                               data_tvalid,
    output logic                               data_tlast,
    input  logic                               data_tready,
    input  logic                               busy,
    input  logic                               missed_ack
);

    localparam int            GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);

    sccb_arb_state_t              state_q, state_d;
    logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]                id_q, id_d;
    logic [SCCB_REGWRITE_W-1:0]   wdata_q, wdata_d;
    logic                         nack_q, nack_d;
    logic [GW-1:0]                gap_cnt_q, gap_cnt_d;
    logic                         done_q, done_d;

    logic [NUM_REQ-1:0]           grant;
    logic [IW-1:0]                grant_idx;
    logic [SCCB_REGWRITE_W-1:0]   sel_data;
    logic                         arb_en;
    logic                         accept;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Holding off during the completion pulse keeps done-to-ready spacing at GAP_CYCLES+1.
    assign arb_en    = (state_q == ARB_IDLE) && !done_q;
    assign accept    = arb_en && (|req_valid);
    assign req_ready = arb_en ? grant : '0;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_data = req_data[i*SCCB_REGWRITE_W +: SCCB_REGWRITE_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        wdata_d     = wdata_q;
        nack_d      = nack_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        cmd_valid   = 1'b0;
        data_tvalid = 1'b0;
        data_tlast  = 1'b0;
        data_tdata  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d  = ARB_CMD;
                    rr_ptr_d = grant_idx;
                    id_d     = grant_idx;
                    wdata_d  = sel_data;
                    nack_d   = 1'b0;
                end
            end
            ARB_CMD: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = ARB_BYTE_HI;
            end
            ARB_BYTE_HI: begin
                data_tvalid = 1'b1;
                data_tdata  = wdata_q[23:16];
                if (data_tready) state_d = ARB_BYTE_LO;
            end
            ARB_BYTE_LO: begin
                data_tvalid = 1'b1;
                data_tdata  = wdata_q[15:8];
                if (data_tready) state_d = ARB_BYTE_DATA;
            end
            ARB_BYTE_DATA: begin
                data_tvalid = 1'b1;
                data_tlast  = 1'b1;
                data_tdata  = wdata_q[7:0];
                if (data_tready) state_d = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (!busy) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? ARB_IDLE : ARB_GAP;
                end
            end
            ARB_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ARB_IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = ARB_IDLE;
        endcase

        if (missed_ack && state_q != ARB_IDLE && state_q != ARB_GAP) nack_d = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= IW'(NUM_REQ - 1);
            id_q      <= '0;
            wdata_q   <= '0;
            nack_q    <= 1'b0;
            gap_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            wdata_q   <= wdata_d;
            nack_q    <= nack_d;
            gap_cnt_q <= gap_cnt_d;
            done_q    <= done_d;
        end
    end

    assign cmd_address        = DEV_ADDR;
    assign cmd_start          = cmd_valid;
    assign cmd_write_multiple = cmd_valid;
    assign cmd_stop           = cmd_valid;
    assign cmd_read           = 1'b0;
    assign cmd_write          = 1'b0;

    assign done_valid = done_q;
    assign done_id    = done_q ? id_q : '0;
    assign done_nack  = done_q & nack_q;
    assign active     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Scoreboard bench: stimulus queues expected grants/bytes/completions, a monitor pops and compares.
module tb_sccb_write_arbiter;

    localparam int GAP = 16;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [47:0] req_data = '0;
    logic [1:0]  req_ready;
    logic        done_valid, done_id, done_nack, active;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop, cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  data_tdata;
    logic        data_tvalid, data_tlast;
    logic        data_tready = 1'b1;
    logic        busy = 1'b0;
    logic        missed_ack = 1'b0;

    always #5 clk_in = ~clk_in;

    sccb_write_arbiter #(.NUM_REQ(2), .DEV_ADDR(7'h3C), .GAP_CYCLES(GAP)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_ready          (req_ready),
        .done_valid         (done_valid),
        .done_id            (done_id),
        .done_nack          (done_nack),
        .active             (active),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_read           (cmd_read),
        .cmd_write          (cmd_write),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .data_tdata         (data_tdata),
        .data_tvalid        (data_tvalid),
        .data_tlast         (data_tlast),
        .data_tready        (data_tready),
        .busy               (busy),
        .missed_ack         (missed_ack)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [23:0] src_q0[$];
    logic [23:0] src_q1[$];
    logic [1:0]  exp_grant[$];
    logic [8:0]  exp_bytes[$];
    logic [1:0]  exp_done[$];

    int stall_idx  = -1;
    int stall_left = 0;
    int cmd_hold   = 0;
    int drain_cnt  = 0;
    int byte_idx   = 0;
    bit nack_arm   = 1'b0;

    bit prev_acc   = 1'b0;
    bit gap_exact  = 1'b0;
    int last_done  = -1000;
    int stall_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({req_ready, done_valid, done_id, done_nack, active, cmd_start, cmd_read,
                    cmd_write, cmd_write_multiple, cmd_stop, cmd_valid, data_tdata,
                    data_tvalid, data_tlast, cmd_address});
    endfunction

    task automatic push_req(input int id, input logic [23:0] w, input bit nack);
        if (id == 0) src_q0.push_back(w);
        else         src_q1.push_back(w);
        exp_grant.push_back((id == 0) ? 2'b01 : 2'b10);
        exp_bytes.push_back({1'b0, w[23:16]});
        exp_bytes.push_back({1'b0, w[15:8]});
        exp_bytes.push_back({1'b1, w[7:0]});
        exp_done.push_back({1'(id), nack});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_grant.size() + exp_bytes.size() + exp_done.size()) != 0 && n < budget) begin
            @(posedge clk_in);
            n++;
        end
        check({name, "_timeout"}, 32'(n < budget), 32'd1);
        repeat (4) @(posedge clk_in);
    endtask

    always @(posedge clk_in) cyc <= cyc + 1;

    // Requesters: hold valid/data from their queue until accepted.
    always begin
        logic [1:0] acc;
        @(negedge clk_in);
        acc = req_ready;
        @(posedge clk_in);
        #1;
        if (acc[0] && src_q0.size() > 0) void'(src_q0.pop_front());
        if (acc[1] && src_q1.size() > 0) void'(src_q1.pop_front());
        req_valid[0]     = (src_q0.size() > 0);
        req_valid[1]     = (src_q1.size() > 0);
        req_data[23:0]   = (src_q0.size() > 0) ? src_q0[0] : 24'h0;
        req_data[47:24]  = (src_q1.size() > 0) ? src_q1[0] : 24'h0;
    end

    // i2c_master model: decides ready/busy/missed_ack for the coming edge.
    always @(negedge clk_in) begin
        if (rst_in) begin
            busy        = 1'b0;
            cmd_ready   = 1'b1;
            data_tready = 1'b1;
            missed_ack  = 1'b0;
            byte_idx    = 0;
            drain_cnt   = 0;
            stall_left  = 0;
        end else begin
            cmd_ready = 1'b1;
            if (cmd_valid && cmd_hold > 0) begin
                cmd_ready = 1'b0;
                cmd_hold--;
            end
            if (cmd_valid && cmd_ready) busy = 1'b1;
            missed_ack = 1'b0;
            if (data_tvalid && byte_idx == 0 && nack_arm) begin
                missed_ack = 1'b1;
                nack_arm   = 1'b0;
            end
            data_tready = 1'b1;
            if (data_tvalid && byte_idx == stall_idx && stall_left > 0) begin
                data_tready = 1'b0;
                stall_left--;
            end
            if (data_tvalid && data_tready) begin
                if (data_tlast) begin
                    byte_idx  = 0;
                    drain_cnt = 3;
                end else begin
                    byte_idx++;
                end
            end else if (drain_cnt > 0) begin
                drain_cnt--;
                if (drain_cnt == 0) busy = 1'b0;
            end
        end
    end

    // Monitor: samples just before each rising edge.
    always @(negedge clk_in) begin
        #4;
        if (rst_in) begin
            prev_acc = 1'b0;
        end else begin
            if (prev_acc) check("cmd_latency", 32'(cmd_valid), 32'd1);
            prev_acc = |req_ready;
            if (req_ready != 2'b00) begin
                if (exp_grant.size() == 0) begin
                    check("unexpected_grant", 32'(req_ready), 32'd0);
                end else begin
                    check("grant", 32'(req_ready), 32'(exp_grant.pop_front()));
                    check("gap_min", 32'((cyc - last_done) >= GAP + 1), 32'd1);
                    if (gap_exact && last_done >= 0)
                        check("gap_exact", 32'(cyc - last_done), 32'(GAP + 1));
                end
            end
            if (cmd_valid && cmd_ready)
                check("cmd_fields",
                      32'({cmd_start, cmd_write_multiple, cmd_stop, cmd_read, cmd_write, cmd_address}),
                      32'({5'b11100, 7'h3C}));
            if (data_tvalid) begin
                if (exp_bytes.size() == 0) begin
                    check("unexpected_byte", 32'(data_tvalid), 32'd0);
                end else if (data_tready) begin
                    check("byte", 32'({data_tlast, data_tdata}), 32'(exp_bytes.pop_front()));
                end else begin
                    stall_seen++;
                    check("byte_held", 32'({data_tlast, data_tdata}), 32'(exp_bytes[0]));
                end
            end
            if (done_valid) begin
                if (exp_done.size() == 0) check("unexpected_done", 32'(done_valid), 32'd0);
                else check("done_id_nack", 32'({done_id, done_nack}), 32'(exp_done.pop_front()));
                last_done = cyc;
            end
            if (!active)
                check("idle_outputs",
                      32'({cmd_valid, cmd_start, cmd_write_multiple, cmd_stop, cmd_read, cmd_write,
                           data_tvalid, data_tlast, data_tdata}), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset_outputs", outs(), 32'h3C);
        @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (3) @(posedge clk_in);

        // Contention: both held for four writes, grants alternate starting at 0.
        gap_exact = 1'b1;
        @(negedge clk_in);
        push_req(0, 24'h12_34_56, 1'b0);
        push_req(1, 24'h50_00_11, 1'b0);
        push_req(0, 24'h35_03_0A, 1'b0);
        push_req(1, 24'h50_01_22, 1'b0);
        push_req(0, 24'h35_0A_01, 1'b0);
        push_req(1, 24'h50_02_33, 1'b0);
        push_req(0, 24'h38_00_FF, 1'b0);
        push_req(1, 24'h50_03_44, 1'b0);
        wait_drain("contention", 1000);
        gap_exact = 1'b0;

        // Single write with an immediately ready master.
        @(negedge clk_in);
        push_req(0, 24'h30_08_82, 1'b0);
        wait_drain("single", 300);

        // Back-pressure on the low address byte.
        stall_idx  = 1;
        stall_left = 50;
        stall_seen = 0;
        @(negedge clk_in);
        push_req(0, 24'h30_08_82, 1'b0);
        wait_drain("backpressure", 500);
        check("stall_cycles", 32'(stall_seen), 32'd50);
        stall_idx = -1;

        // NACK in the first transaction only; command also held off for 3 cycles.
        cmd_hold = 3;
        nack_arm = 1'b1;
        @(negedge clk_in);
        push_req(0, 24'hAB_CD_EF, 1'b1);
        push_req(0, 24'h01_02_03, 1'b0);
        wait_drain("nack", 500);

        // Gap: requester 1 held continuously.
        gap_exact = 1'b1;
        @(negedge clk_in);
        push_req(1, 24'h60_00_01, 1'b0);
        push_req(1, 24'h60_00_02, 1'b0);
        push_req(1, 24'h60_00_03, 1'b0);
        wait_drain("gap", 500);
        gap_exact = 1'b0;

        // Reset while the data byte is stalled: abort with no completion.
        stall_idx  = 2;
        stall_left = 20;
        @(negedge clk_in);
        push_req(0, 24'h3A_5B_7C, 1'b0);
        exp_done.delete();
        n = 0;
        do begin
            @(posedge clk_in);
            #1;
            n++;
        end while (!data_tlast && n < 200);
        check("reached_byte_data", 32'(data_tlast), 32'd1);
        rst_in = 1'b1;
        #1;
        check("reset_abort_outputs", outs(), 32'h3C);
        exp_bytes.delete();
        stall_idx = -1;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        repeat (30) @(posedge clk_in);

        // After release both request; requester 0 must win first.
        @(negedge clk_in);
        push_req(0, 24'h11_22_33, 1'b0);
        push_req(1, 24'h44_55_66, 1'b0);
        wait_drain("post_reset", 500);

        check("leftover_expectations", 32'(exp_grant.size() + exp_bytes.size() + exp_done.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
